// File: rtl/serial_sequence_generator.sv
// Serializes a parallel word as a frame: marker 101, DATA_W payload bits MSB-first,
// then GAP_CYCLES zero cycles. Every output comes straight from a flop.
module serial_sequence_generator #(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              sout,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] BIT_ONE  = CNT_W'(1);
   localparam logic [3:0]       GAP_LAST = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MARK = 2'd1,
      DATA = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [1:0]        mark_cnt_q, mark_cnt_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]        gap_cnt_q, gap_cnt_d;
   logic              sout_q, sout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              din_ready_q, din_ready_d;

   // Next-state logic: each branch computes what the line shows in the following cycle.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      mark_cnt_d  = mark_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      sout_d      = 1'b0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      din_ready_d = din_ready_q;
      case (state_q)
         IDLE: begin
            if (din_valid) begin
               state_d     = MARK;
               shift_d     = din;
               mark_cnt_d  = 2'd0;
               sout_d      = 1'b1;
               busy_d      = 1'b1;
               din_ready_d = 1'b0;
            end else begin
               busy_d      = 1'b0;
               din_ready_d = 1'b1;
            end
         end
         MARK: begin
            if (mark_cnt_q == 2'd2) begin
               state_d   = DATA;
               bit_cnt_d = {CNT_W{1'b0}};
               sout_d    = shift_q[DATA_W-1];
               shift_d   = shift_q << 1;
            end else begin
               // counter 0 shows the first 1; the bit for counter value n+1 is 0 only at n+1 = 1
               mark_cnt_d = mark_cnt_q + 2'd1;
               sout_d     = (mark_cnt_q == 2'd1);
            end
         end
         DATA: begin
            if (bit_cnt_q == BIT_LAST) begin
               state_d   = GAP;
               gap_cnt_d = 4'd0;
               done_d    = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + BIT_ONE;
               sout_d    = shift_q[DATA_W-1];
               shift_d   = shift_q << 1;
            end
         end
         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d     = IDLE;
               busy_d      = 1'b0;
               din_ready_d = 1'b1;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            din_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers with synchronous reset that aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= {DATA_W{1'b0}};
         mark_cnt_q  <= 2'd0;
         bit_cnt_q   <= {CNT_W{1'b0}};
         gap_cnt_q   <= 4'd0;
         sout_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         din_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         mark_cnt_q  <= mark_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         sout_q      <= sout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         din_ready_q <= din_ready_d;
      end
   end

   assign sout      = sout_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign din_ready = din_ready_q;

endmodule
